// File: rtl/exc_pkg.sv
// Shared types and constants for the exception sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exc_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    HANDLER = 2'd1,
    FAULT   = 2'd2
  } exc_state_t;

  // Exception syndrome codes held in ESR
  localparam logic [3:0] ESR_NONE  = 4'd0;
  localparam logic [3:0] ESR_UNDEF = 4'd1;
  localparam logic [3:0] ESR_IRQ   = 4'd2;
  localparam logic [3:0] ESR_ERET  = 4'd3;

  // MRS system-register selects
  localparam logic [1:0] SREG_ELR    = 2'd0;
  localparam logic [1:0] SREG_ESR    = 2'd1;
  localparam logic [1:0] SREG_STATUS = 2'd2;
  localparam logic [1:0] SREG_COUNT  = 2'd3;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Latency: 2-3 clk from d to q depending on arrival phase.
// Backpressure: none; q follows d continuously.
// Ports: clk, reset (async active-low, clears to 0), d (async level in), q (synchronized out).
module sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception entry/return sequencer for the single-cycle LEGv8 core.
// Latency: exc_taken/exc_kill combinational in the faulting cycle; ELR/ESR/state update on next edge.
// Backpressure: none; the core must honour exc_taken (redirect) and halted (stop fetching).
// Ports: clk, reset (async active-low); pc, not_an_instr, eret from the decoder; ext_irq (async level);
//        sreg_sel picks MRS data; exc_taken/exc_kill/exc_vector drive fetch and write suppression;
//        elr is the ERET target; sreg_rdata is MRS read data; in_handler/halted report mode.
module exception_ctrl
  import exc_pkg::*;
#(
  parameter logic [63:0] VECTOR_ADDR = 64'h0000_0000_0000_00D8,
  parameter int          CNT_W       = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc,
  input  logic        not_an_instr,
  input  logic        eret,
  input  logic        ext_irq,
  input  logic [1:0]  sreg_sel,
  output logic        exc_taken,
  output logic        exc_kill,
  output logic [63:0] exc_vector,
  output logic [63:0] elr,
  output logic [63:0] sreg_rdata,
  output logic        in_handler,
  output logic        halted
);

  exc_state_t       state, state_n;
  logic [3:0]       esr, esr_n;
  logic [63:0]      elr_n;
  logic [CNT_W-1:0] count, count_n;
  logic             irq_s;

  sync2 u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ext_irq),
    .q     (irq_s)
  );

  assign exc_vector = VECTOR_ADDR;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
      elr   <= '0;
      esr   <= ESR_NONE;
      count <= '0;
    end else begin
      state <= state_n;
      elr   <= elr_n;
      esr   <= esr_n;
      count <= count_n;
    end
  end

  always_comb begin
    state_n    = state;
    elr_n      = elr;
    esr_n      = esr;
    exc_taken  = 1'b0;
    exc_kill   = 1'b0;
    in_handler = 1'b0;
    halted     = 1'b0;
    sreg_rdata = '0;

    unique case (state)
      RUN: begin
        // Only the highest-priority cause is recorded; a still-held IRQ is retaken later.
        if (not_an_instr) begin
          exc_taken = 1'b1;
          exc_kill  = 1'b1;
          elr_n     = pc;
          esr_n     = ESR_UNDEF;
          state_n   = HANDLER;
        end else if (eret) begin
          exc_taken = 1'b1;
          exc_kill  = 1'b1;
          elr_n     = pc;
          esr_n     = ESR_ERET;
          state_n   = HANDLER;
        end else if (irq_s) begin
          // elr points at the interrupted instruction so it re-executes after return.
          exc_taken = 1'b1;
          exc_kill  = 1'b1;
          elr_n     = pc;
          esr_n     = ESR_IRQ;
          state_n   = HANDLER;
        end
      end
      HANDLER: begin
        // IRQ is masked here; it becomes eligible again on the first RUN cycle.
        in_handler = 1'b1;
        if (not_an_instr) begin
          exc_kill = 1'b1;
          state_n  = FAULT;
        end else if (eret) begin
          state_n = RUN;
        end
      end
      FAULT: begin
        halted   = 1'b1;
        exc_kill = 1'b1;
      end
      default: state_n = RUN;
    endcase

    count_n = count;
    if (exc_taken && (count != {CNT_W{1'b1}})) begin
      count_n = count + CNT_W'(1);
    end

    unique case (sreg_sel)
      SREG_ELR:    sreg_rdata = elr;
      SREG_ESR:    sreg_rdata = {60'b0, esr};
      SREG_STATUS: sreg_rdata = {62'b0, halted, in_handler};
      default:     sreg_rdata[CNT_W-1:0] = count;
    endcase

    // Decoder flags must not leak out while the block is held in reset.
    if (!reset) begin
      exc_taken  = 1'b0;
      exc_kill   = 1'b0;
      in_handler = 1'b0;
      halted     = 1'b0;
      sreg_rdata = '0;
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
module tb_exception_ctrl;

  localparam int S_TAKEN = 0;
  localparam int S_KILL  = 1;
  localparam int S_INH   = 2;
  localparam int S_HALT  = 3;
  localparam int S_ELR   = 4;
  localparam int S_RDATA = 5;
  localparam int S_VEC   = 6;

  typedef struct {
    string       tag;
    int          sig;
    logic [63:0] val;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] pc;
  logic        not_an_instr;
  logic        eret;
  logic        ext_irq;
  logic [1:0]  sreg_sel;
  logic        exc_taken;
  logic        exc_kill;
  logic [63:0] exc_vector;
  logic [63:0] elr;
  logic [63:0] sreg_rdata;
  logic        in_handler;
  logic        halted;

  exp_t sb[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  exception_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .not_an_instr (not_an_instr),
    .eret         (eret),
    .ext_irq      (ext_irq),
    .sreg_sel     (sreg_sel),
    .exc_taken    (exc_taken),
    .exc_kill     (exc_kill),
    .exc_vector   (exc_vector),
    .elr          (elr),
    .sreg_rdata   (sreg_rdata),
    .in_handler   (in_handler),
    .halted       (halted)
  );

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] observe(input int sig);
    case (sig)
      S_TAKEN: observe = {63'b0, exc_taken};
      S_KILL:  observe = {63'b0, exc_kill};
      S_INH:   observe = {63'b0, in_handler};
      S_HALT:  observe = {63'b0, halted};
      S_ELR:   observe = elr;
      S_RDATA: observe = sreg_rdata;
      default: observe = exc_vector;
    endcase
  endfunction

  task automatic expect_sig(input string tag, input int sig, input logic [63:0] v);
    exp_t e;
    e.tag = tag;
    e.sig = sig;
    e.val = v;
    sb.push_back(e);
  endtask

  // Outputs settle mid-cycle; everything queued for this cycle is compared on the falling edge.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk_eq(e.tag, observe(e.sig), e.val);
    end
  end

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic one_exc();
    not_an_instr = 1'b1;
    expect_sig("t6_taken", S_TAKEN, 64'd1);
    tick();
    not_an_instr = 1'b0;
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit found;
    reset = 1'b0;
    pc = '0;
    not_an_instr = 1'b0;
    eret = 1'b0;
    ext_irq = 1'b0;
    sreg_sel = 2'd0;
    repeat (2) @(posedge clk);
    #1;

    // Held in reset: decoder flag must not produce a redirect
    not_an_instr = 1'b1;
    expect_sig("rst_taken", S_TAKEN, 64'd0);
    expect_sig("rst_kill",  S_KILL,  64'd0);
    expect_sig("rst_elr",   S_ELR,   64'd0);
    expect_sig("rst_vec",   S_VEC,   64'hD8);
    tick();
    not_an_instr = 1'b0;
    reset = 1'b1;
    expect_sig("rel_taken", S_TAKEN, 64'd0);
    tick();

    // Undefined instruction in RUN
    pc = 64'h100;
    not_an_instr = 1'b1;
    expect_sig("t2_taken", S_TAKEN, 64'd1);
    expect_sig("t2_kill",  S_KILL,  64'd1);
    tick();
    not_an_instr = 1'b0;
    sreg_sel = 2'd1;
    expect_sig("t2_elr",   S_ELR,   64'h100);
    expect_sig("t2_esr",   S_RDATA, 64'd1);
    expect_sig("t2_inh",   S_INH,   64'd1);
    expect_sig("t2_taken0", S_TAKEN, 64'd0);
    tick();

    // Asynchronous reset in the middle of a handler cycle
    expect_sig("t1_elr", S_ELR, 64'd0);
    expect_sig("t1_inh", S_INH, 64'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    sreg_sel = 2'd3;
    expect_sig("t1_cnt", S_RDATA, 64'd0);
    expect_sig("t1_inh_rel", S_INH, 64'd0);
    tick();

    // IRQ through the synchronizer
    pc = 64'h300;
    sreg_sel = 2'd1;
    #2 ext_irq = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (exc_taken) begin
        found = 1'b1;
        break;
      end
    end
    chk_eq("t3_irq_lat", {63'b0, found}, 64'd1);
    @(posedge clk);
    #1;
    expect_sig("t3_elr", S_ELR,   64'h300);
    expect_sig("t3_esr", S_RDATA, 64'd2);
    expect_sig("t3_inh", S_INH,   64'd1);
    tick();
    repeat (3) begin
      expect_sig("t3_noretake", S_TAKEN, 64'd0);
      tick();
    end

    // ERET with IRQ pending: return, then IRQ taken at the return target
    eret = 1'b1;
    pc = 64'h304;
    expect_sig("t4_eret_taken", S_TAKEN, 64'd0);
    expect_sig("t4_eret_kill",  S_KILL,  64'd0);
    tick();
    eret = 1'b0;
    pc = 64'h300;
    expect_sig("t4_irq_taken", S_TAKEN, 64'd1);
    expect_sig("t4_irq_kill",  S_KILL,  64'd1);
    tick();
    expect_sig("t4_esr", S_RDATA, 64'd2);
    expect_sig("t4_elr", S_ELR,   64'h300);
    expect_sig("t4_inh", S_INH,   64'd1);
    tick();
    ext_irq = 1'b0;
    repeat (3) tick();
    eret = 1'b1;
    tick();
    eret = 1'b0;
    expect_sig("t4_run_inh",   S_INH,   64'd0);
    expect_sig("t4_run_taken", S_TAKEN, 64'd0);
    tick();

    // Exception counter: 2 IRQs so far, then 10 more, then saturation
    repeat (10) one_exc();
    sreg_sel = 2'd3;
    expect_sig("t6_cnt12", S_RDATA, 64'd12);
    tick();
    repeat (290) one_exc();
    sreg_sel = 2'd3;
    expect_sig("t6_sat", S_RDATA, 64'd255);
    tick();
    sreg_sel = 2'd2;
    expect_sig("t6_sel2_run", S_RDATA, 64'd0);
    tick();

    // ERET outside handler, then double fault
    pc = 64'h200;
    eret = 1'b1;
    expect_sig("t5_taken", S_TAKEN, 64'd1);
    tick();
    eret = 1'b0;
    expect_sig("t5_sel2_hdl", S_RDATA, 64'd1);
    tick();
    sreg_sel = 2'd1;
    expect_sig("t5_esr", S_RDATA, 64'd3);
    expect_sig("t5_elr", S_ELR,   64'h200);
    tick();
    pc = 64'h204;
    not_an_instr = 1'b1;
    expect_sig("t5_df_taken", S_TAKEN, 64'd0);
    expect_sig("t5_df_kill",  S_KILL,  64'd1);
    tick();
    sreg_sel = 2'd2;
    for (int i = 0; i < 20; i++) begin
      not_an_instr = 1'($urandom_range(0, 1));
      eret = 1'($urandom_range(0, 1));
      ext_irq = 1'($urandom_range(0, 1));
      pc = 64'h400 + 64'(i * 4);
      expect_sig("t5_halt",  S_HALT,  64'd1);
      expect_sig("t5_kill",  S_KILL,  64'd1);
      expect_sig("t5_taken", S_TAKEN, 64'd0);
      expect_sig("t5_sel2",  S_RDATA, 64'd2);
      expect_sig("t5_elr_h", S_ELR,   64'h200);
      tick();
    end

    // Only reset leaves FAULT
    not_an_instr = 1'b0;
    eret = 1'b0;
    ext_irq = 1'b0;
    expect_sig("fin_halt", S_HALT, 64'd0);
    #2 reset = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_eq("sb_drain", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
